// File: rtl/tlut_result_drain.sv
// Result drain for the TLUT SIMD cell: captures the accumulated lane vector into one of
// two ping-pong banks and streams it out one lane per valid/ready beat.
// Optional build macro: RESULT_SAT_EN (unsigned saturation of lanes to OUT_WIDTH plus a
// sticky sat_flag); without it lanes are truncated and sat_flag is tied low.
module tlut_result_drain #(
    parameter int unsigned DIM_MULT  = 16,
    parameter int unsigned ACC_WIDTH = 16,
    parameter int unsigned OUT_WIDTH = 16,
    parameter int unsigned IDX_WIDTH = $clog2(DIM_MULT)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          capture,
    input  logic [DIM_MULT*ACC_WIDTH-1:0] accumulated_mult,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_WIDTH-1:0]          out_data,
    output logic [IDX_WIDTH-1:0]          out_idx,
    output logic                          out_last,
    output logic                          overflow,
    output logic                          sat_flag,
    output logic [1:0]                    occupancy
);

    localparam logic [IDX_WIDTH-1:0] LastIdx = IDX_WIDTH'(DIM_MULT - 1);

    typedef enum logic [0:0] {StIdle, StStream} state_e;

    state_e                 state_q;
    logic                   wr_ptr_q;
    logic                   rd_ptr_q;
    logic [IDX_WIDTH-1:0]   lane_cnt_q;
    logic [1:0]             occ_q;
    logic [1:0]             occ_d;
    logic                   overflow_q;
    logic [ACC_WIDTH-1:0]   bank_q [2][DIM_MULT];

    logic                   streaming;
    logic [ACC_WIDTH-1:0]   cur_lane;
    logic [OUT_WIDTH-1:0]   conv_data;
    logic                   hs;
    logic                   last_hs;
    logic                   cap;
    logic                   accept;
    logic                   drop;

    // Beat presentation, handshake decode and capture arbitration.
    always_comb begin
        streaming = (state_q == StStream);
        cur_lane  = bank_q[rd_ptr_q][lane_cnt_q];
`ifdef RESULT_SAT_EN
        // Any bit above OUT_WIDTH set means the lane does not fit.
        conv_data = ((cur_lane >> OUT_WIDTH) != '0) ? '1 : OUT_WIDTH'(cur_lane);
`else
        conv_data = OUT_WIDTH'(cur_lane);
`endif
        out_valid = streaming & enable;
        out_data  = streaming ? conv_data : '0;
        out_idx   = lane_cnt_q;
        out_last  = streaming && (lane_cnt_q == LastIdx);
        hs        = out_valid & out_ready;
        last_hs   = hs & out_last;
        cap       = capture & enable;
        // A full buffer still accepts when the read bank is freed in the same cycle.
        accept    = cap & ((occ_q != 2'd2) | last_hs);
        drop      = cap & ~accept;
        unique case ({accept, last_hs})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    // Drain FSM, bank pointers, lane counter and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            lane_cnt_q <= '0;
            occ_q      <= 2'd0;
            overflow_q <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (last_hs) begin
                lane_cnt_q <= '0;
                rd_ptr_q   <= ~rd_ptr_q;
            end else if (hs) begin
                lane_cnt_q <= lane_cnt_q + 1'b1;
            end
            occ_q <= occ_d;
            // Keyed off the next occupancy so the first beat follows capture by one cycle
            // and a second full bank streams without a bubble.
            state_q <= (occ_d != 2'd0) ? StStream : StIdle;
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Bank storage; write pointer never equals the read bank while it is still being read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < int'(DIM_MULT); i++) begin
                    bank_q[b][i] <= '0;
                end
            end
        end else if (accept) begin
            for (int i = 0; i < int'(DIM_MULT); i++) begin
                bank_q[wr_ptr_q][i] <= accumulated_mult[i*ACC_WIDTH +: ACC_WIDTH];
            end
        end
    end

`ifdef RESULT_SAT_EN
    logic sat_q;

    // Sticky saturation flag, set when a clipped beat is handed off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q <= 1'b0;
        end else if (hs && ((cur_lane >> OUT_WIDTH) != '0)) begin
            sat_q <= 1'b1;
        end
    end

    assign sat_flag = sat_q;
`else
    assign sat_flag = 1'b0;
`endif

    assign overflow  = overflow_q;
    assign occupancy = occ_q;

endmodule
